// File: rtl/ldl_round_wrr.sv
// rtl/ldl_round_wrr.sv - weighted round-robin arbiter with class-of-service priority
// Only the highest active class competes; a winner keeps the grant for weight+1 accepted cycles.
module ldl_round_wrr #(
    parameter  int BIN_WIDTH = 3,
    parameter  int COS_WIDTH = 2,
    parameter  int WGT_WIDTH = 4,
    localparam int REQ_WIDTH = 1 << BIN_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [REQ_WIDTH-1:0]                req,
    input  logic [REQ_WIDTH-1:0][COS_WIDTH-1:0] cos,
    input  logic [REQ_WIDTH-1:0][WGT_WIDTH-1:0] weight,
    input  logic                                ready,
    output logic                                valid,
    output logic [REQ_WIDTH-1:0]                hot,
    output logic [BIN_WIDTH-1:0]                bin,
    output logic                                last
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                 state, state_n;
    logic [REQ_WIDTH-1:0]   hot_n;
    logic [BIN_WIDTH-1:0]   bin_n;
    logic                   last_n;
    logic [WGT_WIDTH-1:0]   cnt, cnt_n;
    logic [BIN_WIDTH-1:0]   ptr, ptr_n;

    logic [COS_WIDTH-1:0]   top;
    logic [REQ_WIDTH-1:0]   cand;
    logic [BIN_WIDTH-1:0]   win;
    logic                   update;
    logic                   keep;

    assign valid = (state == GRANT);

    // Highest class among asserted requests, and the requesters belonging to it.
    always_comb begin
        top  = '0;
        cand = '0;
        for (int i = 0; i < REQ_WIDTH; i++) begin
            if (req[i] && (cos[i] > top)) begin
                top = cos[i];
            end
        end
        for (int i = 0; i < REQ_WIDTH; i++) begin
            cand[i] = req[i] && (cos[i] == top);
        end
    end

    // Rotating search starting just after the last winner; the last winner is tried last.
    always_comb begin
        logic                 found;
        logic [BIN_WIDTH-1:0] idx;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= REQ_WIDTH; k++) begin
            idx = ptr + BIN_WIDTH'(k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign update = !valid || ready;
    assign keep   = valid && ready && cand[bin] && (cnt != '0);

    always_comb begin
        state_n = state;
        hot_n   = hot;
        bin_n   = bin;
        last_n  = last;
        cnt_n   = cnt;
        ptr_n   = ptr;
        if (update) begin
            if (keep) begin
                state_n = GRANT;
                cnt_n   = cnt - WGT_WIDTH'(1);
                last_n  = (cnt == WGT_WIDTH'(1));
            end else if (cand != '0) begin
                state_n    = GRANT;
                bin_n      = win;
                ptr_n      = win;
                hot_n      = '0;
                hot_n[win] = 1'b1;
                cnt_n      = weight[win];
                last_n     = (weight[win] == '0);
            end else begin
                state_n = IDLE;
                hot_n   = '0;
                bin_n   = '0;
                last_n  = 1'b0;
                cnt_n   = '0;
            end
        end
    end

    // Pointer resets to the top index so the first search after reset starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            hot   <= '0;
            bin   <= '0;
            last  <= 1'b0;
            cnt   <= '0;
            ptr   <= BIN_WIDTH'(REQ_WIDTH - 1);
        end else begin
            state <= state_n;
            hot   <= hot_n;
            bin   <= bin_n;
            last  <= last_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
        end
    end

endmodule

// File: tb/tb_ldl_round_wrr.sv
// tb/tb_ldl_round_wrr.sv - self-checking bench for ldl_round_wrr
module tb_ldl_round_wrr;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      req;
    logic [7:0][1:0] cos;
    logic [7:0][3:0] weight;
    logic            ready;
    logic            valid;
    logic [7:0]      hot;
    logic [2:0]      bin;
    logic            last;

    int checks = 0;
    int failures = 0;

    int log_bin[$];
    int log_last[$];

    bit m_valid;
    int m_owner;
    int m_left;
    int m_ptr;
    bit m_last;

    always #5 clk = ~clk;

    ldl_round_wrr dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .cos    (cos),
        .weight (weight),
        .ready  (ready),
        .valid  (valid),
        .hot    (hot),
        .bin    (bin),
        .last   (last)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: owner keeps the grant while it stays in the top class and grants remain.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_owner = 0;
            m_left  = 0;
            m_ptr   = 7;
            m_last  = 1'b0;
        end else if (!(m_valid && !ready)) begin
            int top;
            top = -1;
            for (int i = 0; i < 8; i++)
                if (req[i] && int'(cos[i]) > top) top = int'(cos[i]);
            if (top < 0) begin
                m_valid = 1'b0;
                m_owner = 0;
                m_left  = 0;
                m_last  = 1'b0;
            end else begin
                if (m_valid && req[m_owner] && int'(cos[m_owner]) == top && m_left > 0) begin
                    m_left = m_left - 1;
                end else begin
                    for (int k = 1; k <= 8; k++) begin
                        int j;
                        j = (m_ptr + k) % 8;
                        if (req[j] && int'(cos[j]) == top) begin
                            m_owner = j;
                            m_ptr   = j;
                            m_left  = int'(weight[j]);
                            break;
                        end
                    end
                end
                m_valid = 1'b1;
                m_last  = (m_left == 0);
            end
        end
    end

    always @(negedge clk) begin
        chk("valid", int'(valid), int'(m_valid));
        chk("bin", int'(bin), m_valid ? m_owner : 0);
        chk("hot", int'(hot), m_valid ? (1 << m_owner) : 0);
        chk("last", int'(last), int'(m_last));
        if (valid && ready) begin
            log_bin.push_back(int'(bin));
            log_last.push_back(int'(last));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_log();
        log_bin.delete();
        log_last.delete();
    endtask

    task automatic chk_log(input string name, input int n, input int eb[8], input int el[8]);
        chk({name, "_len"}, int'(log_bin.size() >= n), 1);
        for (int i = 0; i < n && i < log_bin.size(); i++) begin
            chk($sformatf("%s_bin%0d", name, i), log_bin[i], eb[i]);
            chk($sformatf("%s_last%0d", name, i), log_last[i], el[i]);
        end
    endtask

    task automatic do_reset();
        req    = '0;
        cos    = '0;
        weight = '0;
        ready  = 1'b1;
        rst_n  = 1'b0;
        step(1);
        rst_n  = 1'b1;
    endtask

    initial begin
        req    = '0;
        cos    = '0;
        weight = '0;
        ready  = 1'b1;
        rst_n  = 1'b0;
        step(2);
        chk("rst_valid", int'(valid), 0);
        chk("rst_hot", int'(hot), 0);
        chk("rst_bin", int'(bin), 0);
        chk("rst_last", int'(last), 0);
        rst_n = 1'b1;
        step(1);
        chk("idle_valid", int'(valid), 0);

        // Plain round robin, weight 0
        req = 8'ha5;
        clear_log();
        chk("t1_lat0", int'(valid), 0);
        step(1);
        chk("t1_lat1", int'(valid), 1);
        step(6);
        chk_log("t1", 6, '{0, 2, 5, 7, 0, 2, 0, 0}, '{1, 1, 1, 1, 1, 1, 0, 0});
        req = '0;
        step(2);
        chk("t1_idle", int'(valid), 0);

        // Weighted bursts
        do_reset();
        weight[0] = 4'd2;
        weight[2] = 4'd0;
        req = 8'h05;
        clear_log();
        step(9);
        chk_log("t2", 8, '{0, 0, 0, 2, 0, 0, 0, 2}, '{0, 0, 1, 1, 0, 0, 1, 1});

        // Stall mid-burst with request noise
        do_reset();
        weight[0] = 4'd5;
        req = 8'h01;
        clear_log();
        step(2);
        ready = 1'b0;
        req = 8'h00;
        step(1);
        chk("t3_s0_valid", int'(valid), 1);
        chk("t3_s0_bin", int'(bin), 0);
        chk("t3_s0_last", int'(last), 0);
        req = 8'h80;
        step(1);
        chk("t3_s1_hot", int'(hot), 1);
        chk("t3_s1_last", int'(last), 0);
        req = 8'h00;
        step(1);
        chk("t3_s2_valid", int'(valid), 1);
        chk("t3_s2_bin", int'(bin), 0);
        ready = 1'b1;
        req = 8'h01;
        step(5);
        chk_log("t3", 6, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 1, 0, 0});

        // Class of service filtering
        do_reset();
        req = 8'hff;
        cos = {2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
        clear_log();
        step(7);
        chk_log("t4", 6, '{3, 7, 3, 7, 3, 7, 0, 0}, '{1, 1, 1, 1, 1, 1, 0, 0});

        // Preemption by a higher class
        do_reset();
        weight[0] = 4'd7;
        req = 8'h01;
        step(3);
        chk("t5_pre_bin", int'(bin), 0);
        req = 8'h21;
        cos[5] = 2'd1;
        step(1);
        chk("t5_preempt_bin", int'(bin), 5);
        chk("t5_preempt_last", int'(last), 1);
        step(2);
        chk("t5_hold_bin", int'(bin), 5);
        req = 8'h01;
        step(1);
        chk("t5_back_bin", int'(bin), 0);
        chk("t5_back_last", int'(last), 0);

        // Early burst end, then asynchronous reset while granting
        do_reset();
        weight[0] = 4'd3;
        req = 8'h13;
        step(1);
        chk("t6_first_bin", int'(bin), 0);
        chk("t6_first_last", int'(last), 0);
        req = 8'h12;
        step(1);
        chk("t6_early_bin", int'(bin), 1);
        chk("t6_early_last", int'(last), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_arst_valid", int'(valid), 0);
        chk("t6_arst_hot", int'(hot), 0);
        chk("t6_arst_bin", int'(bin), 0);
        chk("t6_arst_last", int'(last), 0);
        step(1);
        rst_n = 1'b1;
        req = 8'h13;
        step(1);
        chk("t6_after_rst_bin", int'(bin), 0);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
